// File: rtl/membus_pkg.sv
// Shared widths, FSM states and the per-master request bundle for the memory-bus arbiter.
package membus_pkg;

    localparam int unsigned MA_W  = 15;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned MB_W  = 36;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    // Everything a master drives towards memory, bundled so one select picks it all.
    typedef struct packed {
        logic             rq_cyc;
        logic             rd_rq;
        logic             wr_rq;
        logic [MA_W-1:0]  ma;
        logic [SEL_W-1:0] sel;
        logic             fmc_select;
        logic             wr_rs;
        logic [MB_W-1:0]  mb_out;
    } membus_req_t;

endpackage

// File: rtl/membus_mux.sv
// Owner-select of the request/address/data path. The bus side is zero whenever the
// port is not owned, since downstream modules OR all masters together.
module membus_mux
    import membus_pkg::*;
(
    input  logic            owner,
    input  logic            busy,
    input  logic            addr_phase,
    input  logic            data_phase,
    input  membus_req_t     m0_req,
    input  membus_req_t     m1_req,
    input  logic            bus_addr_ack,
    input  logic            bus_rd_rs,
    input  logic [MB_W-1:0] bus_mb_in,
    output membus_req_t     bus_req,
    output logic            own_rq_cyc,
    output logic            own_wr_rs,
    output logic [1:0]      addr_ack,
    output logic [1:0]      rd_rs,
    output logic [MB_W-1:0] m0_mb_in,
    output logic [MB_W-1:0] m1_mb_in
);

    membus_req_t own_req;

    assign own_req    = owner ? m1_req : m0_req;
    assign own_rq_cyc = own_req.rq_cyc;
    assign own_wr_rs  = own_req.wr_rs;

    // Master -> memory: request/address held while owned, write data only in the data phase.
    always_comb begin
        bus_req = '0;
        if (busy) begin
            bus_req.rq_cyc     = own_req.rq_cyc;
            bus_req.rd_rq      = own_req.rd_rq;
            bus_req.wr_rq      = own_req.wr_rq;
            bus_req.ma         = own_req.ma;
            bus_req.sel        = own_req.sel;
            bus_req.fmc_select = own_req.fmc_select;
        end
        if (data_phase) begin
            bus_req.wr_rs  = own_req.wr_rs;
            bus_req.mb_out = own_req.mb_out;
        end
    end

    // Memory -> master: responses steered to the owner only, in the phase they belong to.
    always_comb begin
        addr_ack = '0;
        rd_rs    = '0;
        m0_mb_in = '0;
        m1_mb_in = '0;
        if (addr_phase) begin
            addr_ack[owner] = bus_addr_ack;
        end
        if (data_phase) begin
            rd_rs[owner] = bus_rd_rs;
            if (owner) begin
                m1_mb_in = bus_mb_in;
            end else begin
                m0_mb_in = bus_mb_in;
            end
        end
    end

endmodule

// File: rtl/membus_arb2.sv
// Two-master arbiter for one memory-bus port: grants one master per memory cycle,
// tracks it through address acknowledge and restart, and flags non-existent memory.
module membus_arb2
    import membus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter bit          RR      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_rq_cyc,
    input  logic             m1_rq_cyc,
    input  logic             m0_rd_rq,
    input  logic             m1_rd_rq,
    input  logic             m0_wr_rq,
    input  logic             m1_wr_rq,
    input  logic [MA_W-1:0]  m0_ma,
    input  logic [MA_W-1:0]  m1_ma,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic             m0_fmc_select,
    input  logic             m1_fmc_select,
    input  logic             m0_wr_rs,
    input  logic             m1_wr_rs,
    input  logic [MB_W-1:0]  m0_mb_out,
    input  logic [MB_W-1:0]  m1_mb_out,
    output logic             m0_addr_ack,
    output logic             m1_addr_ack,
    output logic             m0_rd_rs,
    output logic             m1_rd_rs,
    output logic [MB_W-1:0]  m0_mb_in,
    output logic [MB_W-1:0]  m1_mb_in,
    output logic             m0_nxm,
    output logic             m1_nxm,
    output logic             bus_rq_cyc,
    output logic             bus_rd_rq,
    output logic             bus_wr_rq,
    output logic             bus_wr_rs,
    output logic [MA_W-1:0]  bus_ma,
    output logic [SEL_W-1:0] bus_sel,
    output logic             bus_fmc_select,
    output logic [MB_W-1:0]  bus_mb_out,
    input  logic             bus_addr_ack,
    input  logic             bus_rd_rs,
    input  logic [MB_W-1:0]  bus_mb_in,
    output logic             busy,
    output logic             owner
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_rd_q, cyc_rd_d;
    logic             cyc_wr_q, cyc_wr_d;
    logic             rd_seen_q, rd_seen_d;
    logic [1:0]       nxm_q, nxm_d;

    logic        grant;
    logic        cyc_done;
    logic        own_rq_cyc;
    logic        own_wr_rs;
    logic [1:0]  addr_ack;
    logic [1:0]  rd_rs;
    membus_req_t m0_req, m1_req, bus_req;

    assign m0_req = '{rq_cyc: m0_rq_cyc, rd_rq: m0_rd_rq, wr_rq: m0_wr_rq, ma: m0_ma,
                      sel: m0_sel, fmc_select: m0_fmc_select, wr_rs: m0_wr_rs,
                      mb_out: m0_mb_out};
    assign m1_req = '{rq_cyc: m1_rq_cyc, rd_rq: m1_rd_rq, wr_rq: m1_wr_rq, ma: m1_ma,
                      sel: m1_sel, fmc_select: m1_fmc_select, wr_rs: m1_wr_rs,
                      mb_out: m1_mb_out};

    membus_mux u_mux (
        .owner        (owner_q),
        .busy         (state_q != StIdle),
        .addr_phase   (state_q == StAddr),
        .data_phase   (state_q == StData),
        .m0_req       (m0_req),
        .m1_req       (m1_req),
        .bus_addr_ack (bus_addr_ack),
        .bus_rd_rs    (bus_rd_rs),
        .bus_mb_in    (bus_mb_in),
        .bus_req      (bus_req),
        .own_rq_cyc   (own_rq_cyc),
        .own_wr_rs    (own_wr_rs),
        .addr_ack     (addr_ack),
        .rd_rs        (rd_rs),
        .m0_mb_in     (m0_mb_in),
        .m1_mb_in     (m1_mb_in)
    );

    // Winner among current requesters; a tie alternates (RR) or favours master 0.
    always_comb begin
        if (m0_rq_cyc && m1_rq_cyc) begin
            grant = RR ? !last_q : 1'b0;
        end else begin
            grant = m1_rq_cyc;
        end
    end

    // Cycle completion by type; a read-modify-write needs rd_rs seen on an earlier cycle.
    always_comb begin
        case ({cyc_rd_q, cyc_wr_q})
            2'b10:   cyc_done = bus_rd_rs;
            2'b01:   cyc_done = own_wr_rs;
            2'b11:   cyc_done = own_wr_rs && rd_seen_q;
            // A cycle requesting neither read nor write has nothing to wait for.
            default: cyc_done = 1'b1;
        endcase
    end

    // Next-state logic for the grant/address/data sequence and the timeout counter.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        cyc_rd_d  = cyc_rd_q;
        cyc_wr_d  = cyc_wr_q;
        rd_seen_d = rd_seen_q;
        nxm_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (m0_rq_cyc || m1_rq_cyc) begin
                    state_d   = StAddr;
                    owner_d   = grant;
                    cnt_d     = '0;
                    cyc_rd_d  = grant ? m1_rd_rq : m0_rd_rq;
                    cyc_wr_d  = grant ? m1_wr_rq : m0_wr_rq;
                    rd_seen_d = 1'b0;
                end
            end
            StAddr: begin
                if (bus_addr_ack) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else if (!own_rq_cyc) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = StIdle;
                    nxm_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bus_rd_rs) begin
                    rd_seen_d = 1'b1;
                end
                if (cyc_done) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset abandons any cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            cyc_rd_q  <= 1'b0;
            cyc_wr_q  <= 1'b0;
            rd_seen_q <= 1'b0;
            nxm_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            cyc_rd_q  <= cyc_rd_d;
            cyc_wr_q  <= cyc_wr_d;
            rd_seen_q <= rd_seen_d;
            nxm_q     <= nxm_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign owner          = owner_q;
    assign m0_addr_ack    = addr_ack[0];
    assign m1_addr_ack    = addr_ack[1];
    assign m0_rd_rs       = rd_rs[0];
    assign m1_rd_rs       = rd_rs[1];
    assign m0_nxm         = nxm_q[0];
    assign m1_nxm         = nxm_q[1];
    assign bus_rq_cyc     = bus_req.rq_cyc;
    assign bus_rd_rq      = bus_req.rd_rq;
    assign bus_wr_rq      = bus_req.wr_rq;
    assign bus_wr_rs      = bus_req.wr_rs;
    assign bus_ma         = bus_req.ma;
    assign bus_sel        = bus_req.sel;
    assign bus_fmc_select = bus_req.fmc_select;
    assign bus_mb_out     = bus_req.mb_out;

endmodule

// File: tb/tb_membus_arb2.sv
// Bench for membus_arb2: directed per-cycle table, a timeout sequence and a random run
// checked against a transaction-level model of the port.
module tb_membus_arb2;
    import membus_pkg::*;

    localparam int unsigned TO   = 64;
    localparam logic [35:0] BMBI = 36'o123456654321;

    typedef struct packed {
        bit       rst;
        bit [1:0] rq, rd, wr, wrs;
        bit       ack, rrs;
    } vin_t;

    typedef struct packed {
        bit       busy, own, brq;
        bit [1:0] mack, mrrs;
        bit       bwrs;
        bit [1:0] dph;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    typedef struct packed {
        logic        busy, own, brq, brd, bwr, bwrs;
        logic [14:0] ma;
        logic [3:0]  sel;
        logic        fmc;
        logic [35:0] mbo;
        logic [1:0]  ack, rrs, nxm;
        logic [35:0] mbi0, mbi1;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rq, rd, wr, wrs, fmc;
    logic [14:0] ma [2];
    logic [3:0]  sel [2];
    logic [35:0] mbo [2];
    logic [1:0]  aack, rrs_o, nxm;
    logic [35:0] mbi [2];
    logic        brq, brd, bwr, bwrs, bfmc;
    logic [14:0] bma;
    logic [3:0]  bsel;
    logic [35:0] bmbo;
    logic        b_ack, b_rrs;
    logic [35:0] b_mbi;
    logic        busy, owner;

    int   n_vec = 0;
    int   n_miss = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    membus_arb2 #(.TIMEOUT(TO), .RR(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_rq_cyc      (rq[0]),
        .m1_rq_cyc      (rq[1]),
        .m0_rd_rq       (rd[0]),
        .m1_rd_rq       (rd[1]),
        .m0_wr_rq       (wr[0]),
        .m1_wr_rq       (wr[1]),
        .m0_ma          (ma[0]),
        .m1_ma          (ma[1]),
        .m0_sel         (sel[0]),
        .m1_sel         (sel[1]),
        .m0_fmc_select  (fmc[0]),
        .m1_fmc_select  (fmc[1]),
        .m0_wr_rs       (wrs[0]),
        .m1_wr_rs       (wrs[1]),
        .m0_mb_out      (mbo[0]),
        .m1_mb_out      (mbo[1]),
        .m0_addr_ack    (aack[0]),
        .m1_addr_ack    (aack[1]),
        .m0_rd_rs       (rrs_o[0]),
        .m1_rd_rs       (rrs_o[1]),
        .m0_mb_in       (mbi[0]),
        .m1_mb_in       (mbi[1]),
        .m0_nxm         (nxm[0]),
        .m1_nxm         (nxm[1]),
        .bus_rq_cyc     (brq),
        .bus_rd_rq      (brd),
        .bus_wr_rq      (bwr),
        .bus_wr_rs      (bwrs),
        .bus_ma         (bma),
        .bus_sel        (bsel),
        .bus_fmc_select (bfmc),
        .bus_mb_out     (bmbo),
        .bus_addr_ack   (b_ack),
        .bus_rd_rs      (b_rrs),
        .bus_mb_in      (b_mbi),
        .busy           (busy),
        .owner          (owner)
    );

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input vin_t i, input vout_t o);
        tbl.push_back('{i: i, o: o});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rq = '0; rd = '0; wr = '0; wrs = '0;
        b_ack = 1'b0; b_rrs = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model state: one outstanding memory cycle at most.
    bit   m_active, m_acked, m_rd, m_wr, m_rd_seen;
    int   m_who, m_waited, m_last;
    bit   [1:0] m_nxm;

    task automatic model_step();
        bit done;
        m_nxm = '0;
        if (reset) begin
            m_active = 1'b0;
            m_last   = 1;
        end else if (!m_active) begin
            if (rq != 2'b00) begin
                m_who     = (rq == 2'b11) ? 1 - m_last : (rq[1] ? 1 : 0);
                m_active  = 1'b1;
                m_acked   = 1'b0;
                m_rd      = rd[m_who];
                m_wr      = wr[m_who];
                m_rd_seen = 1'b0;
                m_waited  = 0;
            end
        end else if (!m_acked) begin
            if (b_ack) begin
                m_acked = 1'b1;
            end else if (!rq[m_who]) begin
                m_active = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_nxm[m_who] = 1'b1;
                    m_active     = 1'b0;
                end
            end
        end else begin
            if (m_rd && m_wr)  done = wrs[m_who] && m_rd_seen;
            else if (m_wr)     done = wrs[m_who];
            else if (m_rd)     done = b_rrs;
            else               done = 1'b1;
            if (b_rrs) m_rd_seen = 1'b1;
            if (done) begin
                m_active = 1'b0;
                m_last   = m_who;
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t e = '0;
        e.nxm  = m_nxm;
        e.busy = m_active;
        if (m_active) begin
            e.own = m_who[0];
            e.brq = rq[m_who];
            e.brd = rd[m_who];
            e.bwr = wr[m_who];
            e.ma  = ma[m_who];
            e.sel = sel[m_who];
            e.fmc = fmc[m_who];
            if (!m_acked) begin
                e.ack[m_who] = b_ack;
            end else begin
                e.bwrs       = wrs[m_who];
                e.mbo        = mbo[m_who];
                e.rrs[m_who] = b_rrs;
                if (m_who == 1) e.mbi1 = b_mbi;
                else            e.mbi0 = b_mbi;
            end
        end
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t got, exp;
        int   k;
        int   o;

        ma[0] = 15'o01234; sel[0] = 4'd0; fmc = 2'b10; mbo[0] = 36'o111111222222;
        ma[1] = 15'o04321; sel[1] = 4'd5;              mbo[1] = 36'o777777000000;
        b_mbi = BMBI;
        do_reset();

        // Reset state
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_owner", owner, 1'b0);
        chk("reset_bus", {brq, brd, bwr, bwrs, bma, bsel, bfmc, bmbo}, '0);
        chk("reset_master", {aack, rrs_o, nxm, mbi[0], mbi[1]}, '0);
        tick();

        // Read from m0: ack at +3, rd_rs at +5
        add(11'b0_01_01_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_01_01_00_00_0_0, 10'b1_0_1_00_00_0_00);
        add(11'b0_01_01_00_00_0_0, 10'b1_0_1_00_00_0_00);
        add(11'b0_01_01_00_00_1_0, 10'b1_0_1_01_00_0_00);
        add(11'b0_00_00_00_00_0_0, 10'b1_0_0_00_00_0_01);
        add(11'b0_00_00_00_00_0_1, 10'b1_0_0_00_01_0_01);
        add(11'b0_00_00_00_00_0_0, 10'b0_0_0_00_00_0_00);
        // Ties after reset: m0, then m1, then alternation on the next tie
        add(11'b1_00_00_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_11_11_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_11_11_00_00_1_0, 10'b1_0_1_01_00_0_00);
        add(11'b0_10_10_00_00_0_1, 10'b1_0_0_00_01_0_01);
        add(11'b0_11_11_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_11_11_00_00_1_0, 10'b1_1_1_10_00_0_00);
        add(11'b0_01_01_00_00_0_1, 10'b1_1_0_00_10_0_10);
        add(11'b0_01_01_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_01_01_00_00_1_0, 10'b1_0_1_01_00_0_00);
        add(11'b0_00_00_00_00_0_1, 10'b1_0_0_00_01_0_01);
        add(11'b0_00_00_00_00_0_0, 10'b0_0_0_00_00_0_00);
        // m1 write, wr_rs two cycles after ack
        add(11'b0_10_00_10_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_10_00_10_00_1_0, 10'b1_1_1_10_00_0_00);
        add(11'b0_00_00_00_00_0_0, 10'b1_1_0_00_00_0_10);
        add(11'b0_00_00_00_10_0_0, 10'b1_1_0_00_00_1_10);
        add(11'b0_00_00_00_00_0_0, 10'b0_0_0_00_00_0_00);
        // m0 read-modify-write with an early wr_rs
        add(11'b0_01_01_01_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_01_01_01_00_1_0, 10'b1_0_1_01_00_0_00);
        add(11'b0_00_00_00_01_0_0, 10'b1_0_0_00_00_1_01);
        add(11'b0_00_00_00_00_0_0, 10'b1_0_0_00_00_0_01);
        add(11'b0_00_00_00_00_0_1, 10'b1_0_0_00_01_0_01);
        add(11'b0_00_00_00_01_0_0, 10'b1_0_0_00_00_1_01);
        add(11'b0_00_00_00_00_0_0, 10'b0_0_0_00_00_0_00);
        // Reset in DATA with m1 pending
        add(11'b0_01_01_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_01_01_00_00_1_0, 10'b1_0_1_01_00_0_00);
        add(11'b1_10_10_00_00_0_0, 10'b1_0_0_00_00_0_01);
        add(11'b0_10_10_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_10_10_00_00_1_0, 10'b1_1_1_10_00_0_00);
        add(11'b0_00_00_00_00_0_1, 10'b1_1_0_00_10_0_10);
        add(11'b0_00_00_00_00_0_0, 10'b0_0_0_00_00_0_00);
        // Abort before ack, then ack together with abort, then strays in IDLE
        add(11'b0_01_01_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_01_01_00_00_0_0, 10'b1_0_1_00_00_0_00);
        add(11'b0_00_00_00_00_0_0, 10'b1_0_0_00_00_0_00);
        add(11'b0_00_00_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_01_01_00_00_0_0, 10'b0_0_0_00_00_0_00);
        add(11'b0_00_00_00_00_1_0, 10'b1_0_0_01_00_0_00);
        add(11'b0_00_00_00_00_0_1, 10'b1_0_0_00_01_0_01);
        add(11'b0_00_00_00_00_1_1, 10'b0_0_0_00_00_0_00);

        foreach (tbl[n]) begin
            reset = tbl[n].i.rst;
            rq    = tbl[n].i.rq;
            rd    = tbl[n].i.rd;
            wr    = tbl[n].i.wr;
            wrs   = tbl[n].i.wrs;
            b_ack = tbl[n].i.ack;
            b_rrs = tbl[n].i.rrs;
            #1;
            o = tbl[n].o.own ? 1 : 0;
            chk($sformatf("t%0d_busy", n), busy, tbl[n].o.busy);
            if (tbl[n].o.busy) chk($sformatf("t%0d_owner", n), owner, tbl[n].o.own);
            chk($sformatf("t%0d_bus_rq_cyc", n), brq, tbl[n].o.brq);
            chk($sformatf("t%0d_addr_ack", n), aack, tbl[n].o.mack);
            chk($sformatf("t%0d_rd_rs", n), rrs_o, tbl[n].o.mrrs);
            chk($sformatf("t%0d_bus_wr_rs", n), bwrs, tbl[n].o.bwrs);
            chk($sformatf("t%0d_nxm", n), nxm, 2'b00);
            chk($sformatf("t%0d_bus_addr", n), {brd, bwr, bma, bsel, bfmc},
                tbl[n].o.busy ? {rd[o], wr[o], ma[o], sel[o], fmc[o]} : 22'd0);
            chk($sformatf("t%0d_bus_mb_out", n), bmbo,
                (tbl[n].o.dph != 2'b00) ? mbo[o] : 36'd0);
            chk($sformatf("t%0d_m0_mb_in", n), mbi[0], tbl[n].o.dph[0] ? BMBI : 36'd0);
            chk($sformatf("t%0d_m1_mb_in", n), mbi[1], tbl[n].o.dph[1] ? BMBI : 36'd0);
            tick();
        end

        // Non-existent memory: nxm exactly TO cycles after grant, m1 served next
        do_reset();
        rq = 2'b01; rd = 2'b01;
        #1;
        chk("to_idle_busy", busy, 1'b0);
        tick();
        rq = 2'b11; rd = 2'b11;
        k = 0;
        while (k <= 200) begin
            tick();
            k++;
            if (nxm != 2'b00) break;
        end
        chk("to_latency", k, TO);
        chk("to_nxm", nxm, 2'b01);
        chk("to_bus_rq_low", brq, 1'b0);
        chk("to_busy_low", busy, 1'b0);
        rq = 2'b10; rd = 2'b10;
        tick();
        chk("to_m1_busy", busy, 1'b1);
        chk("to_m1_owner", owner, 1'b1);
        chk("to_nxm_one_cycle", nxm, 2'b00);
        b_ack = 1'b1;
        #1;
        chk("to_m1_ack", aack, 2'b10);
        tick();
        rq = 2'b00; rd = 2'b00; b_ack = 1'b0; b_rrs = 1'b1;
        #1;
        chk("to_m1_rd_rs", rrs_o, 2'b10);
        tick();
        b_rrs = 1'b0;

        // Random traffic against the model
        do_reset();
        m_active = 1'b0; m_last = 1; m_nxm = '0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                if (rq[i]) begin
                    if ($urandom_range(0, 11) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    k      = $urandom_range(0, 2);
                    rq[i]  = 1'b1;
                    rd[i]  = (k != 1);
                    wr[i]  = (k != 0);
                    ma[i]  = 15'($urandom);
                    sel[i] = 4'($urandom);
                    fmc[i] = 1'($urandom);
                end
                wrs[i] = ($urandom_range(0, 5) == 0);
                mbo[i] = {4'($urandom), 32'($urandom)};
            end
            b_ack = ($urandom_range(0, 4) == 0);
            b_rrs = ($urandom_range(0, 4) == 0);
            b_mbi = {4'($urandom), 32'($urandom)};
            #1;
            exp = model_out();
            got = '{busy: busy, own: busy ? owner : 1'b0, brq: brq, brd: brd, bwr: bwr,
                    bwrs: bwrs, ma: bma, sel: bsel, fmc: bfmc, mbo: bmbo, ack: aack,
                    rrs: rrs_o, nxm: nxm, mbi0: mbi[0], mbi1: mbi[1]};
            chk($sformatf("rand%0d", c), got, exp);
            model_step();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/membus_arb2.md
Name: membus_arb2

Overview:
- Two-master arbiter for one processor port of the memory bus.
- Lets a second bus master (data channel or second processor) share a memory port p0 with the arithmetic processor.
- Downstream, fast and core memory modules see exactly one master per cycle.
- Tracks each memory cycle from request through address acknowledge to read/write restart, then releases the port. Flags non-existent memory by timeout.

Parameters:
TIMEOUT, 64, cycles to wait in ADDR for addr_ack before declaring non-existent memory (2..255)
RR, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, master 0 wins

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
m0_rq_cyc, m1_rq_cyc  in  1 each  master requests a memory cycle (level)
m0_rd_rq, m1_rd_rq  in  1 each  read requested (level, valid with rq_cyc)
m0_wr_rq, m1_wr_rq  in  1 each  write requested (level, valid with rq_cyc)
m0_ma, m1_ma  in  15 [21:35]  word address
m0_sel, m1_sel  in  4 [18:21]  module select
m0_fmc_select, m1_fmc_select  in  1 each  fast memory select
m0_wr_rs, m1_wr_rs  in  1 each  write restart pulse, data valid
m0_mb_out, m1_mb_out  in  36 [0:35]  master write data
m0_addr_ack, m1_addr_ack  out  1 each  address acknowledge, forwarded pulse
m0_rd_rs, m1_rd_rs  out  1 each  read restart, forwarded pulse
m0_mb_in, m1_mb_in  out  36 each  read data; zero when not granted
m0_nxm, m1_nxm  out  1 each  one-cycle pulse on timeout
bus_rq_cyc, bus_rd_rq, bus_wr_rq, bus_wr_rs  out  1 each  to memory
bus_ma  out  15  to memory
bus_sel  out  4  to memory
bus_fmc_select  out  1  to memory
bus_mb_out  out  36  to memory; zero when idle (wired-OR bus)
bus_addr_ack, bus_rd_rs  in  1 each  from memory (ORed over modules)
bus_mb_in  in  36  from memory
busy  out  1  port owned
owner  out  1  granted master index, valid when busy

Behaviour:
- One clock and one reset: clk, with synchronous active-high reset.
- Reset values:
  - state = IDLE, busy = 0, owner = 0, last = 1 (master 0 wins the first tie), counter = 0.
  - All bus outputs 0; all per-master outputs 0.
  - Reset mid-cycle abandons the cycle. Bus outputs drop the following cycle.
- States: IDLE, ADDR, DATA.
- IDLE:
  - On any rq_cyc, register owner and go to ADDR on the next edge, so grant latency is 1 cycle.
  - Tie: RR=1 picks !last; RR=0 picks master 0.
  - Non-requesting master never granted.
- ADDR:
  - bus_* request/address outputs combinationally mirror the owner's inputs. The non-owner's inputs are ignored.
  - Latch the owner's rd_rq/wr_rq into cyc_rd/cyc_wr on entry.
  - bus_addr_ack is forwarded to owner_addr_ack the same cycle. Next state is DATA and the counter clears.
  - Owner drops rq_cyc before ack (abort): go to IDLE, no pulses.
  - Counter reaches TIMEOUT-1 with no ack: pulse owner nxm for 1 cycle, go to IDLE. bus_rq_cyc deasserts the same edge.
  - Ack and abort in the same cycle: ack wins.
- DATA:
  - bus_rq_cyc follows the owner's, normally low after ack.
  - bus_wr_rs and bus_mb_out mirror the owner.
  - bus_rd_rs and bus_mb_in are forwarded to the owner only.
  - Completion, then go to IDLE and set last = owner:
    - cyc_rd only: completes on bus_rd_rs.
    - cyc_wr only: completes on owner wr_rs.
    - cyc_rd and cyc_wr (read-modify-write): completes on owner wr_rs. A rd_rs must have been seen first; an earlier wr_rs is forwarded but does not complete.
- IDLE always lasts at least 1 cycle between cycles, giving a dead cycle on the bus.
- The non-owner waiting with rq_cyc high is held with no response; it is granted after release.
- busy = (state != IDLE).
- Stray bus_addr_ack/bus_rd_rs in IDLE are ignored and not forwarded.

Decomposition:
- Shared package membus_pkg:
  - widths MA_W = 15, SEL_W = 4, MB_W = 36;
  - state enum {IDLE, ADDR, DATA}.
- Natural sub-module: membus_mux, a combinational owner-select of request/address/data with zeroing when idle. The FSM and timeout counter stay in the top.

Test Plan:
- m0 read ma=0o01234 sel=0, memory acks at +3 and rd_rs at +5 with mb=0o123456654321 -> m0_mb_in = 0o123456654321 with m0_rd_rs; m1 outputs 0; busy clears the cycle after rd_rs.
- m0 and m1 request the same cycle, RR=1, after reset -> m0 granted first; m1 granted after m0 completes; on the next tie m0 loses once (alternation).
- m1 write, data 0o777777000000, wr_rs at +2 after ack -> bus_mb_out matches on the wr_rs cycle; release the next cycle; m0 never sees addr_ack.
- m0 request, memory never acks, TIMEOUT=64 -> m0_nxm pulses exactly 64 cycles after grant; bus_rq_cyc low the next cycle; m1 then served.
- m0 rd+wr: wr_rs asserted before rd_rs stays busy; after rd_rs, a second wr_rs -> release.
- reset asserted in DATA -> the next cycle all bus outputs are 0 and state is IDLE; a pending m1 request is granted 1 cycle after reset deasserts.
